// File: rtl/tdm_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : tdm_demux_pkg                                              |
// | Description : Shared types and constants for the 16-slot TDM demux.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package tdm_demux_pkg;

  localparam int SLOTS_MAX = 16;
  localparam int S_W       = 4;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Bit k set for every slot k that exists in a frame of 'slots' slots.
  function automatic logic [SLOTS_MAX-1:0] slot_mask(input int slots);
    logic [SLOTS_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < SLOTS_MAX; i++) begin
      m[i] = (i < slots);
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tdm_slot_counter                                           |
// | Description : Slot index counter with clear, load-1, and increment that  |
// |               wraps to 0 after slot SLOTS-1.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tdm_slot_counter
  import tdm_demux_pkg::*;
#(
  parameter int SLOTS = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           load1,
  input  logic           inc,
  output logic [S_W-1:0] count,
  output logic           last
);

  assign last = (count == S_W'(SLOTS - 1));

  // Slot index: clear has priority, then load-1 (slot 0 just taken), then step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load1) begin
      count <= S_W'(1);
    end else if (inc) begin
      if (last) begin
        count <= '0;
      end else begin
        count <= count + S_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tdm_demux_16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tdm_demux_16                                               |
// | Description : Serial TDM demultiplexer. Collects one bit per slot into a |
// |               shadow register and publishes the whole frame on D with a  |
// |               one-cycle valid pulse. HUNT/RUN framing FSM with err pulse |
// |               on misplaced sync.                                         |
// | Option      : TDM_DEMUX_SYNC_CHECK_EN - when defined, a missing sync at  |
// |               slot 0 while locked is a framing error that drops to HUNT. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tdm_demux_16
  import tdm_demux_pkg::*;
#(
  parameter int SLOTS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 sync,
  input  logic                 Y,
  output logic [SLOTS_MAX-1:0] D,
  output logic [S_W-1:0]       S,
  output logic                 valid,
  output logic                 locked,
  output logic                 err
);

  localparam logic [SLOTS_MAX-1:0] c_slot_mask = slot_mask(SLOTS);

  state_t               r_state;
  logic [SLOTS_MAX-1:0] r_shadow;

  state_t               w_state_nxt;
  logic [SLOTS_MAX-1:0] w_frame;
  logic [S_W-1:0]       w_wr_idx;
  logic                 w_wr;
  logic                 w_clear;
  logic                 w_load1;
  logic                 w_inc;
  logic                 w_done;
  logic                 w_err_nxt;
  logic                 w_last;

  tdm_slot_counter #(
    .SLOTS (SLOTS)
  ) u_slot_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (w_clear),
    .load1 (w_load1),
    .inc   (w_inc),
    .count (S),
    .last  (w_last)
  );

  assign locked = (r_state == RUN);

  // Decode one sample strobe into counter ops, shadow write and pulse requests.
  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_wr_idx    = S;
    w_clear     = 1'b0;
    w_load1     = 1'b0;
    w_inc       = 1'b0;
    w_done      = 1'b0;
    w_err_nxt   = 1'b0;
    w_frame     = r_shadow;
    if (en) begin
      case (r_state)
        HUNT: begin
          if (sync) begin
            w_wr        = 1'b1;
            w_wr_idx    = '0;
            w_load1     = 1'b1;
            w_state_nxt = RUN;
          end
        end
        default: begin
          if (sync) begin
            // Sync anywhere but slot 0 realigns and throws away the partial frame.
            w_wr      = 1'b1;
            w_wr_idx  = '0;
            w_load1   = 1'b1;
            w_err_nxt = (S != '0);
          end else if (S != '0) begin
            w_wr   = 1'b1;
            w_inc  = 1'b1;
            w_done = w_last;
          end else begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            w_err_nxt   = 1'b1;
            w_clear     = 1'b1;
            w_state_nxt = HUNT;
`else
            w_wr    = 1'b1;
            w_wr_idx = '0;
            w_load1 = 1'b1;
`endif
          end
        end
      endcase
    end
    if (w_wr) begin
      w_frame[w_wr_idx] = Y;
    end
  end

  // Framing state, shadow capture, frame publish and single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= HUNT;
      r_shadow <= '0;
      D        <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      valid   <= w_done;
      err     <= w_err_nxt;
      if (w_wr) begin
        r_shadow <= w_frame;
      end
      if (w_done) begin
        D <= w_frame & c_slot_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tdm_demux_16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_tdm_demux_16                                            |
// | Description : Self-checking bench for tdm_demux_16 against a slot-level  |
// |               behavioural model. Honours TDM_DEMUX_SYNC_CHECK_EN.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_tdm_demux_16;

  localparam int SLOTS = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        sync;
  logic        Y;
  logic [15:0] D;
  logic [3:0]  S;
  logic        valid;
  logic        locked;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit          m_run;
  int          m_slot;
  bit          m_sh [16];
  logic [15:0] m_D;
  bit          m_valid;
  bit          m_err;

  tdm_demux_16 #(.SLOTS(SLOTS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .sync   (sync),
    .Y      (Y),
    .D      (D),
    .S      (S),
    .valid  (valid),
    .locked (locked),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".S"},      {12'd0, S},      16'(m_slot));
    chk({tag, ".D"},      D,               m_D);
    chk({tag, ".valid"},  {15'd0, valid},  {15'd0, m_valid});
    chk({tag, ".err"},    {15'd0, err},    {15'd0, m_err});
    chk({tag, ".locked"}, {15'd0, locked}, {15'd0, m_run});
    chk({tag, ".excl"},   {15'd0, valid & err}, 16'd0);
  endtask

  task automatic model_reset();
    m_run = 0; m_slot = 0; m_D = '0; m_valid = 0; m_err = 0;
    for (int k = 0; k < 16; k++) m_sh[k] = 0;
  endtask

  // One clock edge of the framing rules, expressed per slot.
  task automatic model_step(input bit e, input bit s, input bit y);
    m_valid = 0;
    m_err   = 0;
    if (!e) return;
    if (!m_run) begin
      if (s) begin m_sh[0] = y; m_slot = 1; m_run = 1; end
    end else if (s) begin
      if (m_slot != 0) m_err = 1;
      m_sh[0] = y;
      m_slot  = 1;
    end else if (m_slot == 0) begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
      m_err = 1;
      m_run = 0;
`else
      m_sh[0] = y;
      m_slot  = 1;
`endif
    end else begin
      m_sh[m_slot] = y;
      if (m_slot == SLOTS - 1) begin
        m_D = '0;
        for (int k = 0; k < SLOTS; k++) m_D[k] = m_sh[k];
        m_valid = 1;
        m_slot  = 0;
      end else begin
        m_slot++;
      end
    end
  endtask

  task automatic cyc(input string tag, input bit e, input bit s, input bit y);
    en = e; sync = s; Y = y;
    @(posedge clk);
    model_step(e, s, y);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [15:0] pat;
    pat = 16'h500D;
    rst_n = 1'b0; en = 1'b0; sync = 1'b0; Y = 1'b0;
    model_reset();

    // Reset state, before and across a clock edge
    #3 check_all("rst0");
    @(posedge clk); #1 check_all("rst1");
    rst_n = 1'b1;

    // Unlocked: en without sync captures nothing
    for (int i = 0; i < 5; i++) cyc("hunt", 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // Known frame 0x500D, sync at slot 0
    for (int k = 0; k < 16; k++) cyc("frame1", 1'b1, (k == 0), pat[k]);
    chk("frame1.Dconst", D, 16'h500D);
    cyc("frame1.idle", 1'b0, 1'b0, 1'b0);

    // Same frame with en toggling 1,0 over 32 cycles
    for (int c = 0; c < 32; c++) begin
      if (c % 2 == 0) cyc("toggle", 1'b1, (c == 0), pat[c/2]);
      else            cyc("toggle", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("toggle.Dconst", D, 16'h500D);

    // Misplaced sync at slot 7: err, D kept, realign
    for (int k = 0; k < 7; k++) cyc("mis.pre", 1'b1, (k == 0), 1'($urandom_range(0, 1)));
    cyc("mis.err", 1'b1, 1'b1, 1'b1);
    chk("mis.Dkept", D, 16'h500D);
    for (int k = 1; k < 16; k++) cyc("mis.post", 1'b1, 1'b0, 1'($urandom_range(0, 1)));

    // Randomized traffic with gaps and occasional syncs
    for (int i = 0; i < 400; i++) begin
      bit e, s;
      e = ($urandom_range(0, 3) != 0);
      if (!m_run)           s = ($urandom_range(0, 2) == 0);
      else if (m_slot == 0) s = ($urandom_range(0, 1) == 0);
      else                  s = ($urandom_range(0, 39) == 0);
      cyc("rand", e, s, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset at slot 9
    for (int k = 0; k < 9; k++) cyc("arst.pre", 1'b1, (k == 0), 1'($urandom_range(0, 1)));
    chk("arst.S9", {12'd0, S}, 16'd9);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("arst.now");
    @(posedge clk); #1 check_all("arst.hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc("arst.hunt", 1'b1, 1'b0, 1'b1);

    // Frame 1 with sync, frame 2 starts without sync
    for (int k = 0; k < 16; k++) cyc("fw.f1", 1'b1, (k == 0), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 16; k++) cyc("fw.f2", 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    cyc("fw.tail", 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tdm_demux_16.md
TDM_DEMUX_16 -- requirements
Module: tdm_demux_16

Interface
REQ-001 SHALL have parameter SLOTS, default 16, meaning slots per frame; legal range 2..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port en, input, 1, sample strobe; one slot is consumed per clk edge with en=1.
REQ-005 SHALL have port sync, input, 1, frame-start marker, qualified by en.
REQ-006 SHALL have port Y, input, 1, multiplexed serial data for the current slot.
REQ-007 SHALL have port D, output, 16, last complete frame; bit k = slot k, bits >= SLOTS read 0.
REQ-008 SHALL have port S, output, 4, index of the slot the next sample is stored into.
REQ-009 SHALL have port valid, output, 1, one-cycle pulse when D is updated.
REQ-010 SHALL have port locked, output, 1, high while in RUN.
REQ-011 SHALL have port err, output, 1, one-cycle pulse on a framing error.

Function
REQ-012 SHALL implement a two-state FSM: HUNT and RUN.
REQ-013 In HUNT, SHALL ignore en=1 cycles with sync=0 (no capture, S stays 0).
REQ-014 In HUNT, en=1 with sync=1 SHALL store Y into shadow[0], set S=1, and enter RUN.
REQ-015 In RUN, en=1 with sync=0 and S!=0 SHALL store Y into shadow[S] and increment S.
REQ-016 On an en=1 edge storing slot SLOTS-1, SHALL copy the full shadow into D on that edge, pulse valid in the following cycle, and wrap S to 0.
REQ-017 Frame latency SHALL be 1 clk from the last-slot sample edge to valid=1, with D already stable.
REQ-018 In RUN, en=1 with sync=1 and S==0 SHALL be a normal slot-0 capture with S set to 1.
REQ-019 In RUN, en=1 with sync=1 and S!=0 SHALL pulse err, discard the partial frame (D unchanged, no valid), store Y into shadow[0], set S=1, and stay in RUN.
REQ-020 en=0 SHALL freeze S, the shadow, the FSM, and D; sync and Y are then ignored.
REQ-021 D SHALL hold its value between valid pulses; valid and err SHALL never both be 1 in the same cycle.
REQ-022 locked SHALL equal (state==RUN).

Reset
REQ-023 rst_n=0 SHALL immediately force HUNT, S=0, D=16'h0000, shadow=0, valid=0, err=0, locked=0, regardless of clk.
REQ-024 Reset mid-frame SHALL discard the partial frame; the first frame after release requires a new sync.

Configuration
REQ-025 Macro TDM_DEMUX_SYNC_CHECK_EN: when defined, in RUN an en=1 edge at S==0 with sync=0 SHALL pulse err, capture nothing, and return to HUNT (S=0).
REQ-026 When TDM_DEMUX_SYNC_CHECK_EN is undefined, that case SHALL be a normal slot-0 capture (freewheel), and sync is required only to acquire lock or realign.

Structure
REQ-027 Package tdm_demux_pkg SHALL hold the state enum (HUNT, RUN), the constant SLOTS_MAX=16, and the constant S_W=4.
REQ-028 The slot counter (load-1, increment, wrap at SLOTS-1, clear) SHALL be sub-module tdm_slot_counter; the FSM, shadow register, and output register stay in tdm_demux_16.

Verification
REQ-029 Reset then en=1 with sync=0 for 5 cycles -> S=0, locked=0, valid=0, D=16'h0000.
REQ-030 sync at slot 0, then Y stream 1,0,1,1,0,0,0,0,0,0,0,0,1,0,1,0 (slots 0..15, en=1 every cycle) -> S counts 1..15,0; D=16'h500D; valid=1 for exactly one cycle, 1 clk after the slot-15 edge.
REQ-031 en toggling 1,0,1,0 across a frame -> S advances only on en=1 edges; D matches REQ-030 after 32 cycles.
REQ-032 sync reasserted at S=7 -> err pulse; D keeps its previous value; S=1 next cycle; the next valid reflects only the new frame.
REQ-033 rst_n dropped asynchronously at S=9 -> all outputs 0 within the same cycle; after release, no capture until sync.
REQ-034 With TDM_DEMUX_SYNC_CHECK_EN, omit sync at the start of frame 2 -> err pulse, locked=0, S=0; without the macro -> frame 2 captured, valid pulses.
